// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and hex-to-seven-segment decode for the display mux
package display_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         SUB_PHASES = 16;

    // Active-low pattern, bit6 = segment a .. bit0 = segment g.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b0000001;
            4'h1:    pattern = 7'b1001111;
            4'h2:    pattern = 7'b0010010;
            4'h3:    pattern = 7'b0000110;
            4'h4:    pattern = 7'b1001100;
            4'h5:    pattern = 7'b0100100;
            4'h6:    pattern = 7'b0100000;
            4'h7:    pattern = 7'b0001111;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0001100;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b1100000;
            4'hC:    pattern = 7'b0110001;
            4'hD:    pattern = 7'b1000010;
            4'hE:    pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/display_timebase.sv
// rtl/display_timebase.sv - prescaler, 16-step sub-phase counter and digit index with frame-end flag
module display_timebase
    import display_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SUB_LEN  = 1,
    parameter int IW       = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [3:0]    sub,
    output logic [IW-1:0] idx,
    output logic          frame_end
);

    localparam int PW = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

    logic [PW-1:0] pre;
    logic          pre_wrap;
    logic          sub_wrap;
    logic          idx_wrap;

    assign pre_wrap  = (pre == PW'(SUB_LEN - 1));
    assign sub_wrap  = pre_wrap && (sub == 4'(SUB_PHASES - 1));
    assign idx_wrap  = (idx == IW'(N_DIGITS - 1));
    assign frame_end = sub_wrap && idx_wrap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre <= '0;
            sub <= '0;
            idx <= '0;
        end else begin
            pre <= pre_wrap ? '0 : pre + PW'(1);
            if (pre_wrap) begin
                sub <= sub + 4'd1;
            end
            if (sub_wrap) begin
                idx <= idx_wrap ? '0 : idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/display_hex_mux.sv
// rtl/display_hex_mux.sv - multiplexed hex display driver with frame-aligned updates, blanking, LZ suppression and PWM
module display_hex_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  power_on,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic                  busy,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   ANODO
);

    localparam int SUB_LEN = CLK_HZ / (REFRESH_HZ * SUB_PHASES);
    localparam int IW      = $clog2(N_DIGITS);

    logic [3:0]            sub;
    logic [IW-1:0]         idx;
    logic                  frame_end;

    logic [4*N_DIGITS-1:0] sh_data, act_data;
    logic [N_DIGITS-1:0]   sh_dp, act_dp;
    logic [N_DIGITS-1:0]   sh_blank, act_blank;
    logic                  sh_lz, act_lz;

    logic [N_DIGITS-1:0]   keep;
    logic                  dark;
    logic [3:0]            nibble;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    display_timebase #(
        .N_DIGITS (N_DIGITS),
        .SUB_LEN  (SUB_LEN),
        .IW       (IW)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .sub       (sub),
        .idx       (idx),
        .frame_end (frame_end)
    );

    // Apply happens before capture so a load on the boundary cycle lands in the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lz     <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            act_lz    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (frame_end && busy) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                act_lz    <= sh_lz;
            end
            if (load) begin
                sh_data  <= data_in;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
                sh_lz    <= lz_en;
                busy     <= 1'b1;
            end else if (frame_end) begin
                busy <= 1'b0;
            end
        end
    end

    // keep[k]: some digit at or above k is nonzero or requests its point, so k stays visible.
    always_comb begin
        logic acc;
        keep = '0;
        acc  = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            acc     = acc | (act_data[4*k +: 4] != 4'h0) | act_dp[k];
            keep[k] = acc;
        end
    end

    always_comb begin
        nibble   = act_data[{idx, 2'b00} +: 4];
        dark     = act_blank[idx] | (act_lz && !keep[idx] && (idx != '0));
        seg_next = dark ? SEG_OFF : seg_decode(nibble);
        dp_next  = dark | ~act_dp[idx];
        an_next  = '1;
        if (power_on && (sub < brightness)) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            SEG   <= SEG_OFF;
            DP    <= 1'b1;
            ANODO <= '1;
        end else begin
            SEG   <= seg_next;
            DP    <= dp_next;
            ANODO <= an_next;
        end
    end

endmodule

// File: tb/tb_display_hex_mux.sv
// tb/tb_display_hex_mux.sv - randomized and directed check of display_hex_mux (8 and 4 digits) against a frame-level model
module tb_display_hex_mux;

    logic        clk = 1'b0;
    logic        reset_n, power_on, load, lz_en;
    logic [3:0]  brightness;
    logic [31:0] data_in;
    logic [7:0]  dp_in, blank_in;

    logic        busy8, busy4, dp8, dp4;
    logic [6:0]  seg8, seg4;
    logic [7:0]  an8;
    logic [3:0]  an4;

    always #5 clk = ~clk;

    display_hex_mux #(.N_DIGITS(8), .CLK_HZ(1600), .REFRESH_HZ(100)) dut8 (
        .clk(clk), .reset_n(reset_n), .power_on(power_on), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
        .brightness(brightness), .busy(busy8), .SEG(seg8), .DP(dp8), .ANODO(an8)
    );

    display_hex_mux #(.N_DIGITS(4), .CLK_HZ(1600), .REFRESH_HZ(100)) dut4 (
        .clk(clk), .reset_n(reset_n), .power_on(power_on), .load(load),
        .data_in(data_in[15:0]), .dp_in(dp_in[3:0]), .blank_in(blank_in[3:0]), .lz_en(lz_en),
        .brightness(brightness), .busy(busy4), .SEG(seg4), .DP(dp4), .ANODO(an4)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0]  dec_tab [16];
    int          t    [2];
    logic [31:0] sh_d [2], ac_d [2];
    logic [7:0]  sh_p [2], ac_p [2], sh_b [2], ac_b [2];
    logic        sh_l [2], ac_l [2], m_busy [2];
    logic [6:0]  e_seg [2];
    logic        e_dp  [2];
    logic [7:0]  e_an  [2];
    int          lowcnt;
    logic [6:0]  seen [8];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame-level model: time counted in clocks since reset, digit shown = (t/16) mod n.
    task automatic step_model(input int d);
        int n, slot, sub, hi, fl;
        logic dark;
        logic [3:0] nib;
        n = (d == 0) ? 8 : 4;
        if (!reset_n) begin
            t[d] = 0; sh_d[d] = 0; ac_d[d] = 0; sh_p[d] = 0; ac_p[d] = 0;
            sh_b[d] = 0; ac_b[d] = 0; sh_l[d] = 0; ac_l[d] = 0; m_busy[d] = 0;
            e_seg[d] = 7'h7F; e_dp[d] = 1'b1; e_an[d] = 8'hFF;
            return;
        end
        slot = (t[d] / 16) % n;
        sub  = t[d] % 16;
        hi   = 0;
        for (int k = 0; k < n; k++)
            if (((ac_d[d] >> (4 * k)) & 32'hF) != 0 || ac_p[d][k]) hi = k;
        nib      = 4'((ac_d[d] >> (4 * slot)) & 32'hF);
        dark     = ac_b[d][slot] || (ac_l[d] && slot > hi);
        e_seg[d] = dark ? 7'h7F : dec_tab[nib];
        e_dp[d]  = dark ? 1'b1 : !ac_p[d][slot];
        e_an[d]  = 8'hFF;
        if (power_on && sub < int'(brightness)) e_an[d][slot] = 1'b0;
        fl = 16 * n;
        if ((t[d] % fl) == fl - 1 && m_busy[d]) begin
            ac_d[d] = sh_d[d]; ac_p[d] = sh_p[d]; ac_b[d] = sh_b[d]; ac_l[d] = sh_l[d];
            m_busy[d] = 1'b0;
        end
        if (load) begin
            sh_d[d] = (d == 0) ? data_in  : {16'h0, data_in[15:0]};
            sh_p[d] = (d == 0) ? dp_in    : {4'h0, dp_in[3:0]};
            sh_b[d] = (d == 0) ? blank_in : {4'h0, blank_in[3:0]};
            sh_l[d] = lz_en;
            m_busy[d] = 1'b1;
        end
        t[d]++;
    endtask

    task automatic cycle();
        step_model(0);
        step_model(1);
        @(posedge clk);
        #1;
        chk("seg8",  {1'b0, seg8},  {1'b0, e_seg[0]});
        chk("dp8",   {7'b0, dp8},   {7'b0, e_dp[0]});
        chk("an8",   an8,           e_an[0]);
        chk("busy8", {7'b0, busy8}, {7'b0, m_busy[0]});
        chk("seg4",  {1'b0, seg4},  {1'b0, e_seg[1]});
        chk("dp4",   {7'b0, dp4},   {7'b0, e_dp[1]});
        chk("an4",   {4'h0, an4},   {4'h0, e_an[1][3:0]});
        chk("busy4", {7'b0, busy4}, {7'b0, m_busy[1]});
        if (an8 != 8'hFF) lowcnt++;
        for (int k = 0; k < 8; k++)
            if (an8[k] == 1'b0) seen[k] = seg8;
    endtask

    task automatic run(input int n);
        lowcnt = 0;
        for (int k = 0; k < 8; k++) seen[k] = 7'h55;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic align(input int m);
        for (int i = 0; i < 256 && (t[0] % 128) != m; i++) cycle();
    endtask

    task automatic pulse_load(input logic [31:0] d);
        data_in = d;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] bset [4];
        dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        bset = '{4'd0, 4'd1, 4'd8, 4'd15};

        reset_n = 1'b0; power_on = 1'b0; load = 1'b0; lz_en = 1'b0;
        brightness = 4'd0; data_in = '0; dp_in = '0; blank_in = '0;
        run(3);
        chk("rst_seg",  {1'b0, seg8},  8'h7F);
        chk("rst_dp",   {7'b0, dp8},   8'h01);
        chk("rst_an",   an8,           8'hFF);
        chk("rst_busy", {7'b0, busy8}, 8'h00);

        reset_n = 1'b1; power_on = 1'b1; brightness = 4'd15;
        pulse_load(32'h1234ABCD);
        chk("busy_set", {7'b0, busy8}, 8'h01);
        run(300);
        chk("dig0_d", {1'b0, seen[0]}, 8'b01000010);
        chk("dig7_1", {1'b0, seen[7]}, 8'b01001111);
        chk("busy_clr", {7'b0, busy8}, 8'h00);

        pulse_load(32'h12345678);
        run(200);
        align(3 * 16 + 5);
        pulse_load(32'h00000000);
        run(200);
        chk("zero_dig5", {1'b0, seen[5]}, 8'b00000001);

        lz_en = 1'b1; dp_in = 8'h04;
        pulse_load(32'h00000F07);
        run(300);
        for (int k = 3; k < 8; k++) chk("lz_dark", {1'b0, seen[k]}, 8'h7F);
        chk("lz_dig2", {1'b0, seen[2]}, 8'b00111000);
        chk("lz_dig1", {1'b0, seen[1]}, 8'b00000001);
        chk("lz_dig0", {1'b0, seen[0]}, 8'b00001111);

        for (int b = 0; b < 4; b++) begin
            brightness = bset[b];
            run(1);
            run(16);
            chk("pwm_duty", 8'(lowcnt), {4'h0, bset[b]});
        end
        power_on = 1'b0;
        run(1);
        run(48);
        chk("power_off", 8'(lowcnt), 8'h00);
        power_on = 1'b1;

        lz_en = 1'b0; dp_in = 8'h00;
        pulse_load(32'hAAAAAAAA);
        run(300);
        pulse_load(32'hBBBBBBBB);
        align(127);
        pulse_load(32'hCCCCCCCC);
        chk("coincide_busy8", {7'b0, busy8}, 8'h01);
        chk("coincide_busy4", {7'b0, busy4}, 8'h01);
        run(140);
        chk("coincide_c", {1'b0, seen[0]}, 8'b00110001);

        align(40);
        pulse_load(32'h11111111);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("midrst_busy", {7'b0, busy8}, 8'h00);
        run(150);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                data_in  = $urandom;
                if ($urandom_range(0, 1) == 0) data_in = data_in & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
                dp_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                blank_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                lz_en    = 1'($urandom);
                load     = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 199) == 0) power_on = ~power_on;
            cycle();
            load = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
